// File: rtl/lbm_pkg.sv
// Shared types for the LBM sweep controller.
//   lbm_state_t : controller FSM state encoding. ST_ERROR exists only when
//                 LBM_DIV_TIMEOUT_EN is defined (divider watchdog build).
//   lbm_bnd_t   : per-cell boundary flags produced by the cell counter.
//   cnt_width   : width needed for a counter that must hold the value n.
package lbm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_INIT      = 4'd1,
    ST_MOM       = 4'd2,
    ST_DIV_START = 4'd3,
    ST_DIV_WAIT  = 4'd4,
    ST_EQ        = 4'd5,
    ST_COLLIDE   = 4'd6,
    ST_STREAM    = 4'd7,
    ST_DONE      = 4'd8
`ifdef LBM_DIV_TIMEOUT_EN
    ,
    ST_ERROR     = 4'd9
`endif
  } lbm_state_t;

  typedef struct packed {
    logic lid;
    logic bottom_wall;
    logic left_wall;
    logic right_wall;
  } lbm_bnd_t;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lbm_sweep_ctrl_if.sv
// Host + datapath signal bundle for lbm_sweep_ctrl.
//   master : controller side (drives strobes, address, status).
//   slave  : host/datapath side (drives start, num_iters, div_valid).
// Handshake: start is a level sampled only while the controller is IDLE;
// div_valid is a level sampled only in DIV_WAIT (one accepted result per
// div_start pulse). state is a debug view of the controller FSM.
interface lbm_sweep_ctrl_if #(
  parameter int NX     = 16,
  parameter int NY     = 16,
  parameter int Q      = 9,
  parameter int ITER_W = 16
);
  import lbm_pkg::*;

  localparam int ADDR_W = $clog2(NX * NY);
  localparam int DIR_W  = $clog2(Q);

  logic              start;
  logic [ITER_W-1:0] num_iters;
  logic              div_valid;

  logic [ADDR_W-1:0] cell_addr;
  logic [DIR_W-1:0]  dir;
  logic              lid;
  logic              bottom_wall;
  logic              left_wall;
  logic              right_wall;
  logic              we_init;
  logic              ld_en_mom;
  logic              div_start;
  logic              ld_en_u;
  logic              ld_en_feq;
  logic              we_fout;
  logic              we_fin;
  logic              busy;
  logic              done;
  logic [ITER_W-1:0] iter_cnt;
  logic              err;
  lbm_state_t        state;

  modport master (
    input  start, num_iters, div_valid,
    output cell_addr, dir, lid, bottom_wall, left_wall, right_wall,
           we_init, ld_en_mom, div_start, ld_en_u, ld_en_feq, we_fout,
           we_fin, busy, done, iter_cnt, err, state
  );

  modport slave (
    output start, num_iters, div_valid,
    input  cell_addr, dir, lid, bottom_wall, left_wall, right_wall,
           we_init, ld_en_mom, div_start, ld_en_u, ld_en_feq, we_fout,
           we_fin, busy, done, iter_cnt, err, state
  );

endinterface

// File: rtl/lbm_cell_counter.sv
// Raster x/y cell counter over an NX x NY grid.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force x=y=0 (priority over en)
//   en       : advance one cell; x wraps NX-1->0 with y++, y wraps NY-1->0
//   addr     : y*NX+x
//   last     : current cell is (NX-1, NY-1)
//   bnd      : boundary flags of the current cell
module lbm_cell_counter
  import lbm_pkg::*;
#(
  parameter int NX     = 16,
  parameter int NY     = 16,
  parameter int ADDR_W = $clog2(NX * NY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output lbm_bnd_t          bnd
);

  localparam int XW = $clog2(NX);
  localparam int YW = $clog2(NY);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_last;
  logic          y_last;

  assign x_last = (x_q == XW'(NX - 1));
  assign y_last = (y_q == YW'(NY - 1));
  assign last   = x_last & y_last;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign addr = ADDR_W'(int'(y_q) * NX + int'(x_q));

  assign bnd.lid         = y_last;
  assign bnd.bottom_wall = (y_q == '0);
  assign bnd.left_wall   = (x_q == '0);
  assign bnd.right_wall  = x_last;

endmodule

// File: rtl/lbm_sweep_ctrl.sv
// LBM sweep controller: sequences an init pass, then num_iters iterations of
// (per-cell moment / divide / equilibrium / collide) followed by a streaming
// sweep over an NX x NY grid with Q directions per cell.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : lbm_sweep_ctrl_if.master (host start/done, datapath strobes,
//                cell address/direction, boundary flags, debug state)
// Optional build macro LBM_DIV_TIMEOUT_EN adds a DIV_WAIT watchdog of
// DIV_TIMEOUT cycles that parks the block in ST_ERROR (err=1) until Reset.
module lbm_sweep_ctrl
  import lbm_pkg::*;
#(
  parameter int NX          = 16,
  parameter int NY          = 16,
  parameter int Q           = 9,
  parameter int ITER_W      = 16,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic             Clk,
  input  logic             Reset,
  lbm_sweep_ctrl_if.master bus
);

  localparam int CELLS  = NX * NY;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int DIR_W  = $clog2(Q);

  lbm_state_t        state_q, state_d;
  logic [DIR_W-1:0]  dir_q, dir_d;
  logic [ITER_W-1:0] num_iters_q, num_iters_d;
  logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
  logic [ITER_W-1:0] iter_next;

  logic              cnt_clr;
  logic              cnt_en;
  logic              cell_last;
  logic [ADDR_W-1:0] cell_addr;
  lbm_bnd_t          bnd;
  logic              dir_last;

  logic              we_init;
  logic              ld_en_mom;
  logic              div_start;
  logic              ld_en_u;
  logic              ld_en_feq;
  logic              we_fout;
  logic              we_fin;
  logic              busy;
  logic              done;
  logic              err;
  logic [DIR_W-1:0]  dir_o;

`ifdef LBM_DIV_TIMEOUT_EN
  localparam int WD_W = cnt_width(DIV_TIMEOUT);
  logic [WD_W-1:0] wdog_q, wdog_d;
`endif

  lbm_cell_counter #(
    .NX     (NX),
    .NY     (NY),
    .ADDR_W (ADDR_W)
  ) u_cell_counter (
    .clk  (Clk),
    .rst  (Reset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .addr (cell_addr),
    .last (cell_last),
    .bnd  (bnd)
  );

  assign dir_last  = (dir_q == DIR_W'(Q - 1));
  assign iter_next = iter_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    num_iters_d = num_iters_q;
    iter_cnt_d  = iter_cnt_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    we_init     = 1'b0;
    ld_en_mom   = 1'b0;
    div_start   = 1'b0;
    ld_en_u     = 1'b0;
    ld_en_feq   = 1'b0;
    we_fout     = 1'b0;
    we_fin      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    dir_o       = '0;
`ifdef LBM_DIV_TIMEOUT_EN
    wdog_d      = wdog_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          num_iters_d = bus.num_iters;
          iter_cnt_d  = '0;
          cnt_clr     = 1'b1;
          dir_d       = '0;
          state_d     = ST_INIT;
        end
      end

      ST_INIT: begin
        busy    = 1'b1;
        we_init = 1'b1;
        cnt_en  = 1'b1;
        if (cell_last) begin
          state_d = (num_iters_q == '0) ? ST_DONE : ST_MOM;
        end
      end

      ST_MOM: begin
        busy      = 1'b1;
        ld_en_mom = 1'b1;
        dir_o     = dir_q;
        if (dir_last) begin
          dir_d   = '0;
          state_d = ST_DIV_START;
        end else begin
          dir_d = dir_q + 1'b1;
        end
      end

      // div_valid is deliberately not looked at here: a result can only
      // belong to this request from the following cycle onwards.
      ST_DIV_START: begin
        busy      = 1'b1;
        div_start = 1'b1;
        state_d   = ST_DIV_WAIT;
`ifdef LBM_DIV_TIMEOUT_EN
        wdog_d    = '0;
`endif
      end

      ST_DIV_WAIT: begin
        busy = 1'b1;
        if (bus.div_valid) begin
          ld_en_u = 1'b1;
          state_d = ST_EQ;
        end
`ifdef LBM_DIV_TIMEOUT_EN
        // wdog_q counts completed DIV_WAIT cycles, so this is the
        // DIV_TIMEOUT-th one; a valid here still wins.
        else if (wdog_q == WD_W'(DIV_TIMEOUT - 1)) begin
          state_d = ST_ERROR;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end

      ST_EQ: begin
        busy      = 1'b1;
        ld_en_feq = 1'b1;
        dir_o     = dir_q;
        if (dir_last) begin
          dir_d   = '0;
          state_d = ST_COLLIDE;
        end else begin
          dir_d = dir_q + 1'b1;
        end
      end

      ST_COLLIDE: begin
        busy    = 1'b1;
        we_fout = 1'b1;
        dir_o   = dir_q;
        if (dir_last) begin
          dir_d   = '0;
          cnt_en  = 1'b1;
          state_d = cell_last ? ST_STREAM : ST_MOM;
        end else begin
          dir_d = dir_q + 1'b1;
        end
      end

      ST_STREAM: begin
        busy   = 1'b1;
        we_fin = 1'b1;
        dir_o  = dir_q;
        if (dir_last) begin
          dir_d  = '0;
          cnt_en = 1'b1;
          if (cell_last) begin
            iter_cnt_d = iter_next;
            state_d    = (iter_next == num_iters_q) ? ST_DONE : ST_MOM;
          end
        end else begin
          dir_d = dir_q + 1'b1;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

`ifdef LBM_DIV_TIMEOUT_EN
      ST_ERROR: begin
        err = 1'b1;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      dir_q       <= '0;
      num_iters_q <= '0;
      iter_cnt_q  <= '0;
`ifdef LBM_DIV_TIMEOUT_EN
      wdog_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      num_iters_q <= num_iters_d;
      iter_cnt_q  <= iter_cnt_d;
`ifdef LBM_DIV_TIMEOUT_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  // Flags are only meaningful while sweeping; idle the outputs to 0 so the
  // reset/idle view of the block is all-zero even though the counter sits
  // on corner cell 0.
  assign bus.cell_addr   = cell_addr;
  assign bus.dir         = dir_o;
  assign bus.lid         = bnd.lid & busy;
  assign bus.bottom_wall = bnd.bottom_wall & busy;
  assign bus.left_wall   = bnd.left_wall & busy;
  assign bus.right_wall  = bnd.right_wall & busy;
  assign bus.we_init     = we_init;
  assign bus.ld_en_mom   = ld_en_mom;
  assign bus.div_start   = div_start;
  assign bus.ld_en_u     = ld_en_u;
  assign bus.ld_en_feq   = ld_en_feq;
  assign bus.we_fout     = we_fout;
  assign bus.we_fin      = we_fin;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.iter_cnt    = iter_cnt_q;
  assign bus.err         = err;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_lbm_sweep_ctrl.sv
// Directed bench for lbm_sweep_ctrl on a 4x4 grid, Q=9, DIV_TIMEOUT=8.
// Inputs are driven 1 time unit after the rising edge, outputs are sampled
// on the falling edge. A small divider model answers each div_start after a
// programmable number of DIV_WAIT cycles.
module tb_lbm_sweep_ctrl;
  import lbm_pkg::*;

  localparam int NX = 4;
  localparam int NY = 4;
  localparam int Q  = 9;
  localparam int IW = 16;

  logic Clk;
  logic Reset;
  int   n_asrt;
  int   n_fail;

  lbm_sweep_ctrl_if #(.NX(NX), .NY(NY), .Q(Q), .ITER_W(IW)) bus ();

  lbm_sweep_ctrl #(
    .NX(NX), .NY(NY), .Q(Q), .ITER_W(IW), .DIV_TIMEOUT(8)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // per-job results
  int r_busy, r_last_busy, r_done_cyc, r_ndiv, r_nldu, r_nmom, r_neq;
  int r_nfout, r_nfin, r_ninit, r_seq_err, r_multi, r_dwait;
  bit r_timeout, r_err_seen;
  logic [3:0] r_flags [16];

  function automatic logic [6:0] strobes();
    return {bus.we_init, bus.ld_en_mom, bus.div_start, bus.ld_en_u,
            bus.ld_en_feq, bus.we_fout, bus.we_fin};
  endfunction

  function automatic logic [3:0] flags();
    return {bus.lid, bus.bottom_wall, bus.left_wall, bus.right_wall};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge Clk); #1;
    Reset = 1'b1;
    repeat (cycles) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  // Driver: accepts a start, then runs the divider model until done, err,
  // an abort (Reset during DIV_WAIT after div_start number abort_div), or
  // the cycle budget runs out. Cycle 0 is the first INIT cycle.
  task automatic run_job(input int iters, input int lat, input int start_inj,
                         input bit dv_in_dstart, input int abort_div,
                         input int max_cyc);
    int  cyc;
    int  since;
    bit  pending;
    bit  fin;
    bit  aborted;
    r_busy = 0; r_last_busy = -1; r_done_cyc = -1; r_ndiv = 0; r_nldu = 0;
    r_nmom = 0; r_neq = 0; r_nfout = 0; r_nfin = 0; r_ninit = 0;
    r_seq_err = 0; r_multi = 0; r_dwait = 0; r_timeout = 0; r_err_seen = 0;
    for (int i = 0; i < 16; i++) r_flags[i] = 4'hx;
    cyc = 0; since = 0; pending = 0; fin = 0; aborted = 0;

    @(posedge Clk); #1;
    bus.start     = 1'b1;
    bus.num_iters = IW'(iters);
    @(posedge Clk); #1;
    bus.start = 1'b0;

    while (!fin) begin
      bus.div_valid = 1'b0;
      bus.start     = 1'b0;
      if (cyc == start_inj) begin
        bus.start     = 1'b1;
        bus.num_iters = IW'(5);
      end
      if (bus.state == ST_DIV_START) begin
        pending = 1;
        since   = 0;
        if (dv_in_dstart) bus.div_valid = 1'b1;
      end else if (pending && bus.state == ST_DIV_WAIT) begin
        since++;
        r_dwait++;
        if (abort_div != 0 && r_ndiv == abort_div) begin
          Reset   = 1'b1;
          aborted = 1;
        end else if (lat != 0 && since == lat) begin
          bus.div_valid = 1'b1;
          pending       = 0;
        end
      end

      @(negedge Clk);
      if (aborted) begin
        fin = 1;
      end else begin
        if (bus.busy) begin
          r_busy++;
          r_last_busy = cyc;
        end
        if ($countones(strobes()) > 1) r_multi++;
        if (bus.div_start) r_ndiv++;
        if (bus.ld_en_u)   r_nldu++;
        if (bus.ld_en_feq) r_neq++;
        if (bus.we_fout)   r_nfout++;
        if (bus.we_init) begin
          if (int'(bus.cell_addr) != r_ninit) r_seq_err++;
          r_flags[r_ninit % 16] = flags();
          r_ninit++;
        end
        if (bus.ld_en_mom) begin
          if (int'(bus.dir) != r_nmom % 9) r_seq_err++;
          r_nmom++;
        end
        if (bus.we_fin) begin
          if (int'(bus.dir) != r_nfin % 9) r_seq_err++;
          if (int'(bus.cell_addr) != (r_nfin / 9) % 16) r_seq_err++;
          r_nfin++;
        end
        if (!(bus.ld_en_mom | bus.ld_en_feq | bus.we_fout | bus.we_fin) &&
            bus.dir != '0) r_seq_err++;
        if (bus.done) begin
          r_done_cyc = cyc;
          fin = 1;
        end
        if (bus.err) begin
          r_err_seen = 1;
          fin = 1;
        end
        cyc++;
        if (!fin && cyc >= max_cyc) begin
          r_timeout = 1;
          fin = 1;
        end
      end
      if (!fin) begin
        @(posedge Clk); #1;
      end
    end
    if (!aborted) chk("job_within_budget", 32'(r_timeout), 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_strobes"}, 32'(strobes()), 0);
    chk({tag, "_flags"}, 32'(flags()), 0);
    chk({tag, "_cell_addr"}, 32'(bus.cell_addr), 0);
    chk({tag, "_dir"}, 32'(bus.dir), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
    chk({tag, "_state"}, 32'(bus.state), 32'(ST_IDLE));
  endtask

  initial begin
    n_asrt = 0;
    n_fail = 0;
    Reset = 1'b1;
    bus.start = 1'b0;
    bus.num_iters = '0;
    bus.div_valid = 1'b0;

    // reset state
    do_reset(3);
    chk_idle("reset");
    chk("reset_iter_cnt", 32'(bus.iter_cnt), 0);

    // num_iters = 0: init pass only
    run_job(0, 3, -1, 0, 0, 100);
    chk("it0_busy_cycles", r_busy, 16);
    chk("it0_init_writes", r_ninit, 16);
    chk("it0_done_cycle", r_done_cyc, 16);
    chk("it0_seq_err", r_seq_err, 0);
    chk("it0_div_pulses", r_ndiv, 0);
    chk("it0_iter_cnt", 32'(bus.iter_cnt), 0);
    chk("it0_busy_at_done", 32'(bus.busy), 0);
    chk("bnd_cell0", 32'(r_flags[0]), 32'(4'b0110));
    chk("bnd_cell3", 32'(r_flags[3]), 32'(4'b0101));
    chk("bnd_cell12", 32'(r_flags[12]), 32'(4'b1010));
    chk("bnd_cell15", 32'(r_flags[15]), 32'(4'b1001));
    chk("bnd_cell5", 32'(r_flags[5]), 32'(4'b0000));
    @(negedge Clk);
    chk_idle("after_done0");

    // baseline: num_iters = 1, divider answers in 3rd DIV_WAIT cycle
    run_job(1, 3, -1, 0, 0, 2000);
    chk("base_busy_cycles", r_busy, 16 + 16 * 31 + 144);
    chk("base_done_cycle", r_done_cyc, r_last_busy + 1);
    chk("base_done_at", r_done_cyc, 656);
    chk("base_div_pulses", r_ndiv, 16);
    chk("base_ld_en_u", r_nldu, 16);
    chk("base_mom", r_nmom, 144);
    chk("base_feq", r_neq, 144);
    chk("base_fout", r_nfout, 144);
    chk("base_fin", r_nfin, 144);
    chk("base_dwait", r_dwait, 48);
    chk("base_seq_err", r_seq_err, 0);
    chk("base_multi_strobe", r_multi, 0);
    chk("base_iter_cnt", 32'(bus.iter_cnt), 1);
    @(negedge Clk);
    chk("base_iter_cnt_hold", 32'(bus.iter_cnt), 1);
    chk("base_idle_state", 32'(bus.state), 32'(ST_IDLE));

    // stray start mid-run and div_valid during DIV_START are ignored
    run_job(1, 3, 100, 1, 0, 2000);
    chk("ign_busy_cycles", r_busy, 656);
    chk("ign_done_at", r_done_cyc, 656);
    chk("ign_div_pulses", r_ndiv, 16);
    chk("ign_ld_en_u", r_nldu, 16);
    chk("ign_iter_cnt", 32'(bus.iter_cnt), 1);
    bus.num_iters = '0;

    // two iterations, 1-cycle divider
    run_job(2, 1, -1, 0, 0, 3000);
    chk("two_busy_cycles", r_busy, 16 + 2 * (16 * 29 + 144));
    chk("two_div_pulses", r_ndiv, 32);
    chk("two_fin", r_nfin, 288);
    chk("two_iter_cnt", 32'(bus.iter_cnt), 2);

    // Reset in DIV_WAIT of cell 7, iteration 2 (div_start number 24)
    run_job(2, 1, -1, 0, 24, 3000);
    chk("abort_div_pulses", r_ndiv, 24);
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk_idle("abort");
    chk("abort_iter_cnt", 32'(bus.iter_cnt), 0);

    // fresh run after the abort
    run_job(1, 2, -1, 0, 0, 2000);
    chk("rerun_busy_cycles", r_busy, 16 + 16 * 30 + 144);
    chk("rerun_init_writes", r_ninit, 16);
    chk("rerun_seq_err", r_seq_err, 0);
    chk("rerun_iter_cnt", 32'(bus.iter_cnt), 1);

`ifdef LBM_DIV_TIMEOUT_EN
    // valid on the 8th DIV_WAIT cycle still succeeds
    run_job(1, 8, -1, 0, 0, 2000);
    chk("wd_edge_busy_cycles", r_busy, 16 + 16 * 36 + 144);
    chk("wd_edge_err", 32'(r_err_seen), 0);
    chk("wd_edge_iter_cnt", 32'(bus.iter_cnt), 1);

    // divider never answers
    run_job(1, 0, -1, 0, 0, 2000);
    chk("wd_err_seen", 32'(r_err_seen), 1);
    chk("wd_dwait", r_dwait, 8);
    chk("wd_div_pulses", r_ndiv, 1);
    chk("wd_err", 32'(bus.err), 1);
    chk("wd_busy", 32'(bus.busy), 0);
    chk("wd_strobes", 32'(strobes()), 0);
    @(posedge Clk); #1;
    bus.start = 1'b1;
    @(posedge Clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("wd_start_ignored_err", 32'(bus.err), 1);
    chk("wd_start_ignored_busy", 32'(bus.busy), 0);
    chk("wd_state", 32'(bus.state), 32'(ST_ERROR));
    do_reset(1);
    chk_idle("wd_reset");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  // global watchdog so the bench always ends
  initial begin
    #500000;
    $display("FAIL global_timeout: observed simulation still running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
